// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter in front of a one-entry ALU result register.
// NREQ requesters each offer an opcode and two operands; the granted request is
// evaluated (add/sub/and/or, wrapping modulo 2^W) and held on rsp_* until the
// consumer takes it. A new request is accepted whenever the slot is empty or
// is being drained in the same cycle, giving one transfer per cycle at full rate.
// Optional feature: define ALU_ARBITER_FLAGS_EN to add the registered result
// flags rsp_zero and rsp_carry.
module alu_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 8,
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [2*NREQ-1:0] req_op,
   input  logic [W*NREQ-1:0] req_a,
   input  logic [W*NREQ-1:0] req_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [W-1:0]      rsp_data,
`ifdef ALU_ARBITER_FLAGS_EN
   output logic [IDW-1:0]    rsp_id,
   output logic              rsp_zero,
   output logic              rsp_carry
`else
   output logic [IDW-1:0]    rsp_id
`endif
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t         state;
   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] grant;
   logic           any_valid;
   logic           accept_ok;
   logic           transfer;
   logic [1:0]     op_sel;
   logic [W-1:0]   a_sel;
   logic [W-1:0]   b_sel;

   // Wrapping ALU result for the four opcodes.
   function automatic logic [W-1:0] alu_result(input logic [1:0] op,
                                               input logic [W-1:0] a,
                                               input logic [W-1:0] b);
      case (op)
         2'd0:    return a + b;
         2'd1:    return a - b;
         2'd2:    return a & b;
         default: return a | b;
      endcase
   endfunction

`ifdef ALU_ARBITER_FLAGS_EN
   // Carry out of add, borrow out of sub (top bit of the W+1 bit difference).
   function automatic logic alu_carry(input logic [1:0] op,
                                      input logic [W-1:0] a,
                                      input logic [W-1:0] b);
      logic [W:0] t;
      t = '0;
      case (op)
         2'd0:    t = {1'b0, a} + {1'b0, b};
         2'd1:    t = {1'b0, a} - {1'b0, b};
         default: t = '0;
      endcase
      return t[W];
   endfunction
`endif

   // Round-robin search: first valid requester at or above rr_ptr, modulo NREQ.
   // Scanning from the far end down lets the nearest candidate overwrite the rest.
   always_comb begin
      int idx;
      idx       = 0;
      any_valid = 1'b0;
      grant     = rr_ptr;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr) + k) % NREQ;
         if (req_valid[idx]) begin
            any_valid = 1'b1;
            grant     = IDW'(idx);
         end
      end
   end

   // Handshake and operand selection; req_ready depends only on control inputs,
   // and is held low while reset is asserted.
   always_comb begin
      accept_ok = (state == EMPTY) || rsp_ready;
      transfer  = any_valid && accept_ok && nreset;
      req_ready = transfer ? (NREQ'(1) << grant) : '0;
      op_sel    = req_op[2*grant +: 2];
      a_sel     = req_a[W*grant +: W];
      b_sel     = req_b[W*grant +: W];
   end

   // Result-slot FSM: captures the granted result, drains on rsp_ready, advances rr_ptr.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state     <= EMPTY;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_id    <= '0;
         rr_ptr    <= '0;
`ifdef ALU_ARBITER_FLAGS_EN
         rsp_zero  <= 1'b0;
         rsp_carry <= 1'b0;
`endif
      end else begin
         if (transfer) begin
            state     <= FULL;
            rsp_valid <= 1'b1;
            rsp_data  <= alu_result(op_sel, a_sel, b_sel);
            rsp_id    <= grant;
            rr_ptr    <= (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
`ifdef ALU_ARBITER_FLAGS_EN
            rsp_zero  <= (alu_result(op_sel, a_sel, b_sel) == '0);
            rsp_carry <= alu_carry(op_sel, a_sel, b_sel);
`endif
         end else if ((state == FULL) && rsp_ready) begin
            state     <= EMPTY;
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed-vector bench for alu_arbiter (NREQ=4, W=8).
// Inputs change 1 ns after the rising edge; outputs are checked mid-cycle.
module tb_alu_arbiter;

   localparam int NREQ = 4;
   localparam int W    = 8;

   logic          clk = 1'b0;
   logic          nreset;
   logic [3:0]    req_valid;
   logic [3:0]    req_ready;
   logic [7:0]    req_op;
   logic [31:0]   req_a;
   logic [31:0]   req_b;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [7:0]    rsp_data;
   logic [1:0]    rsp_id;
`ifdef ALU_ARBITER_FLAGS_EN
   logic          rsp_zero;
   logic          rsp_carry;
`endif

   int errors = 0;
   int checks = 0;

   alu_arbiter #(.NREQ(NREQ), .W(W)) dut (
      .clk       (clk),
      .nreset    (nreset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
`ifdef ALU_ARBITER_FLAGS_EN
      .rsp_id    (rsp_id),
      .rsp_zero  (rsp_zero),
      .rsp_carry (rsp_carry)
`else
      .rsp_id    (rsp_id)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to 1 ns after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      req_op[2*i +: 2] = op;
      req_a[8*i +: 8]  = a;
      req_b[8*i +: 8]  = b;
   endtask

   // One single-requester operation through requester 0, checked one cycle later.
   task automatic alu_op(input string tag, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] exp);
      set_req(0, op, a, b);
      req_valid = 4'b0001;
      step();
      check({tag, "_vld"}, rsp_valid, 1);
      check({tag, "_data"}, rsp_data, exp);
      check({tag, "_id"}, rsp_id, 0);
   endtask

   initial begin
      nreset    = 1'b0;
      req_valid = 4'b1111;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;

      // Reset state, with requests pending and clocks running
      step();
      step();
      check("rst_vld", rsp_valid, 0);
      check("rst_data", rsp_data, 0);
      check("rst_id", rsp_id, 0);
      check("rst_ready", req_ready, 0);

      req_valid = 4'b0000;
      nreset    = 1'b1;
      #2;
      check("idle_ready", req_ready, 0);

      // Single request 0x12 + 0x34
      set_req(0, 2'd0, 8'h12, 8'h34);
      req_valid = 4'b0001;
      #1;
      check("single_rdy", req_ready, 4'b0001);
      step();
      check("single_vld", rsp_valid, 1);
      check("single_data", rsp_data, 8'h46);
      check("single_id", rsp_id, 0);

      // Wrap cases and logic ops (rr_ptr is 1; only requester 0 valid)
      alu_op("sub_wrap", 2'd1, 8'h00, 8'h01, 8'hFF);
`ifdef ALU_ARBITER_FLAGS_EN
      check("sub_carry", rsp_carry, 1);
      check("sub_zero", rsp_zero, 0);
`endif
      alu_op("add_wrap", 2'd0, 8'hFF, 8'h01, 8'h00);
`ifdef ALU_ARBITER_FLAGS_EN
      check("add_carry", rsp_carry, 1);
      check("add_zero", rsp_zero, 1);
`endif
      alu_op("and", 2'd2, 8'hF0, 8'h3C, 8'h30);
`ifdef ALU_ARBITER_FLAGS_EN
      check("and_carry", rsp_carry, 0);
`endif
      alu_op("or", 2'd3, 8'hF0, 8'h0C, 8'hFC);

      // Drain with no new request
      req_valid = 4'b0000;
      step();
      check("drain_vld", rsp_valid, 0);

      // Requester 3 alone moves rr_ptr back to 0
      set_req(3, 2'd0, 8'h01, 8'h02);
      req_valid = 4'b1000;
      step();
      check("r3_data", rsp_data, 8'h03);
      check("r3_id", rsp_id, 3);

      // Round robin with all valid: ids 0,1,2,3,0, data i*0x10+1
      for (int i = 0; i < 4; i++) set_req(i, 2'd0, 8'(i * 16), 8'h01);
      req_valid = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         step();
         check($sformatf("rr%0d_id", n), rsp_id, n % 4);
         check($sformatf("rr%0d_data", n), rsp_data, (n % 4) * 16 + 1);
      end

      // Backpressure: held result id 0 / 0x01, requesters 1 and 2 waiting
      req_valid = 4'b0110;
      rsp_ready = 1'b0;
      for (int n = 0; n < 5; n++) begin
         #1;
         check($sformatf("bp%0d_rdy", n), req_ready, 0);
         step();
         check($sformatf("bp%0d_vld", n), rsp_valid, 1);
         check($sformatf("bp%0d_data", n), rsp_data, 8'h01);
         check($sformatf("bp%0d_id", n), rsp_id, 0);
      end
      rsp_ready = 1'b1;
      #1;
      check("bp_release_rdy", req_ready, 4'b0010);
      step();
      check("bp_acc_id", rsp_id, 1);
      check("bp_acc_data", rsp_data, 8'h11);

      // Asynchronous reset while FULL (rr_ptr is 2 beforehand)
      req_valid = 4'b0000;
      #2;
      nreset = 1'b0;
      #1;
      check("arst_vld", rsp_valid, 0);
      check("arst_data", rsp_data, 0);
      check("arst_id", rsp_id, 0);
      step();
      nreset = 1'b1;
      req_valid = 4'b0110;
      #1;
      check("arst_ptr", req_ready, 4'b0010);
      req_valid = 4'b0100;
      set_req(2, 2'd3, 8'h05, 8'h0A);
      #1;
      check("arst_r2_rdy", req_ready, 4'b0100);
      step();
      check("arst_r2_vld", rsp_valid, 1);
      check("arst_r2_id", rsp_id, 2);
      check("arst_r2_data", rsp_data, 8'h0F);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 The block SHALL have parameter W, default 8, operand and result width.
REQ-003 The block SHALL have a single clock and an asynchronous, active-low reset, exposed as the ports below.
REQ-004 The block SHALL have port clk  in  1  clock; all state SHALL change on its rising edge.
REQ-005 The block SHALL have port nreset  in  1  asynchronous active-low reset.
REQ-006 The block SHALL have port req_valid  in  NREQ  per-requester request valid.
REQ-007 The block SHALL have port req_ready  out  NREQ  per-requester accept; at most one bit high.
REQ-008 The block SHALL have port req_op  in  2*NREQ  opcode of requester i at bits [2i+1:2i]: 0 add, 1 sub, 2 and, 3 or.
REQ-009 The block SHALL have port req_a  in  W*NREQ  operand A of requester i at bits [W*i+W-1:W*i].
REQ-010 The block SHALL have port req_b  in  W*NREQ  operand B, packed the same way as req_a.
REQ-011 The block SHALL have port rsp_valid  out  1  result valid.
REQ-012 The block SHALL have port rsp_ready  in  1  result accepted by the consumer.
REQ-013 The block SHALL have port rsp_data  out  W  result.
REQ-014 The block SHALL have port rsp_id  out  max(1,$clog2(NREQ))  index of the requester that owns rsp_data.

Function
REQ-015 The block SHALL have two FSM states: EMPTY (no result held) and FULL (result held, rsp_valid=1).
REQ-016 The block SHALL define accept_ok = (state==EMPTY) || rsp_ready.
REQ-017 The block SHALL select grant as the first i with req_valid[i]=1, searching from rr_ptr upward modulo NREQ.
REQ-018 The block SHALL drive req_ready[grant]=accept_ok and all other req_ready bits to 0; req_ready SHALL NOT depend on req_op, req_a or req_b.
REQ-019 A transfer SHALL occur when req_valid[i] && req_ready[i]; on that edge the block SHALL register result and i, and state SHALL become FULL.
REQ-020 Latency SHALL be 1 cycle: rsp_valid rises on the edge that accepts the request.
REQ-021 The block SHALL set rr_ptr to (grant+1) mod NREQ on every transfer, and leave it unchanged otherwise.
REQ-022 FULL with rsp_ready=1 and no transfer SHALL go to EMPTY; FULL with rsp_ready=1 and a transfer SHALL stay FULL with the new result.
REQ-023 The block SHALL sustain one transfer per cycle while rsp_ready=1.
REQ-024 The block SHALL hold rsp_data, rsp_id and rsp_valid stable while FULL and rsp_ready=0.
REQ-025 Add and sub SHALL wrap modulo 2^W (e.g. 0xFF+0x01=0x00, 0x00-0x01=0xFF).
REQ-026 A requester holding req_valid SHALL be granted within NREQ transfers.
REQ-027 A requester may change req_valid or operands while not accepted; the block SHALL use only values sampled at the transfer edge.
REQ-028 With no req_valid bits set, the block SHALL drive all req_ready bits to 0 and leave rr_ptr unchanged.

Reset
REQ-029 When nreset=0 (asserted asynchronously), the block SHALL force state EMPTY, rsp_valid=0, rsp_data=0, rsp_id=0, rr_ptr=0 and all req_ready=0.
REQ-030 A reset asserted while FULL SHALL discard the held result without reporting it.
REQ-031 The first transfer after reset release SHALL occur no earlier than the first rising clk edge with nreset=1.

Configuration
REQ-032 Macro ALU_ARBITER_FLAGS_EN SHALL control the result-flag feature.
REQ-033 With ALU_ARBITER_FLAGS_EN defined, the block SHALL add output ports rsp_zero (1: result==0) and rsp_carry (1: carry out of add or borrow of sub; 0 for and/or).
REQ-034 rsp_zero and rsp_carry SHALL be registered with rsp_data, follow its reset and hold rules, and reset to 0.
REQ-035 With ALU_ARBITER_FLAGS_EN undefined, the rsp_zero and rsp_carry ports SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-036 Single request: req0 op=0 a=0x12 b=0x34, rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=0x46, rsp_id=0.
REQ-037 Wrap: op=1 a=0x00 b=0x01 -> rsp_data=0xFF, rsp_carry=1 (flags build); op=0 a=0xFF b=0x01 -> rsp_data=0x00, rsp_zero=1, rsp_carry=1.
REQ-038 Round-robin: all 4 requesters valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0 on consecutive cycles.
REQ-039 Backpressure: rsp_ready=0 for 5 cycles while FULL with req1,req2 valid -> all req_ready=0 and rsp_data/rsp_id stable; on raising rsp_ready, req1 is accepted in the same cycle.
REQ-040 Reset mid-operation: nreset=0 while FULL -> rsp_valid=0 immediately (asynchronously); after release, req2 alone gets rsp_id=2 with rr_ptr having restarted at 0.
REQ-041 Logic ops: op=2 a=0xF0 b=0x3C -> 0x30; op=3 a=0xF0 b=0x0C -> 0xFC.
